// File: rtl/memory_interface_unit.sv
// memory_interface_unit: MAR/MDR bus port with req/ack RAM handshake
// Optional feature macro: MEM_TIMEOUT_EN (abort a WAIT after TIMEOUT_CYCLES cycles without ack)
// Ports: clk, reset (async, active-high); bus (tri0 shared datapath bus);
//   MAR_read/MDR_read load from bus; MDR_write drives MDR onto bus;
//   mem_rd_start/mem_wr_start launch a transaction; mem_busy/mem_done/mem_error status;
//   mem_addr/mem_wdata/mem_we/mem_req to RAM; mem_ack/mem_rdata from RAM.
module memory_interface_unit #(
  parameter int ADDR_WIDTH = 16,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  inout  tri0 [31:0]            bus,
  input  logic                  MAR_read,
  input  logic                  MDR_read,
  input  logic                  MDR_write,
  input  logic                  mem_rd_start,
  input  logic                  mem_wr_start,
  output logic                  mem_busy,
  output logic                  mem_done,
  output logic                  mem_error,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  mem_we,
  output logic                  mem_req,
  input  logic                  mem_ack,
  input  logic [31:0]           mem_rdata
);
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  state_t state_q, state_d;
  // only the addressable MAR bits are kept; the rest would be discarded anyway
  logic [ADDR_WIDTH-1:0] mar_q, mar_d, addr_q, addr_d;
  logic [31:0] mdr_q, mdr_d, wdata_q, wdata_d;
  logic we_q, we_d, req_q, req_d;
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be >= 1");
  end
`ifdef MEM_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic err_q, err_d;
`endif
  always_comb begin
    state_d = state_q;
    mar_d = MAR_read ? bus[ADDR_WIDTH-1:0] : mar_q;
    mdr_d = mdr_q;
    wdata_d = wdata_q;
    addr_d = addr_q;
    we_d = we_q;
    req_d = req_q;
`ifdef MEM_TIMEOUT_EN
    cnt_d = cnt_q;
    err_d = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (MDR_read) mdr_d = bus;
        if (mem_rd_start || mem_wr_start) begin
          state_d = WAIT;
          addr_d = mar_q;
          we_d = !mem_rd_start;
          req_d = 1'b1;
          // snapshot so a same-cycle MDR_read cannot alter the write data
          wdata_d = mdr_q;
`ifdef MEM_TIMEOUT_EN
          cnt_d = '0;
          err_d = 1'b0;
`endif
        end
      end
      WAIT: begin
        if (mem_ack) begin
          state_d = DONE;
          req_d = 1'b0;
          if (!we_q) mdr_d = mem_rdata;
        end
`ifdef MEM_TIMEOUT_EN
        else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          state_d = DONE;
          req_d = 1'b0;
          err_d = 1'b1;
        end else cnt_d = cnt_q + 1'b1;
`endif
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      mar_q <= '0;
      mdr_q <= '0;
      wdata_q <= '0;
      addr_q <= '0;
      we_q <= 1'b0;
      req_q <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      cnt_q <= '0;
      err_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      mar_q <= mar_d;
      mdr_q <= mdr_d;
      wdata_q <= wdata_d;
      addr_q <= addr_d;
      we_q <= we_d;
      req_q <= req_d;
`ifdef MEM_TIMEOUT_EN
      cnt_q <= cnt_d;
      err_q <= err_d;
`endif
    end
  end
  assign bus = MDR_write ? mdr_q : {32{1'bz}};
  assign mem_busy = state_q != IDLE;
  assign mem_done = state_q == DONE;
  assign mem_req = req_q;
  assign mem_we = we_q;
  assign mem_addr = addr_q;
  assign mem_wdata = (mem_busy && we_q) ? wdata_q : mdr_q;
`ifdef MEM_TIMEOUT_EN
  assign mem_error = mem_done && err_q;
`else
  assign mem_error = 1'b0;
`endif
endmodule

// File: tb/tb_memory_interface_unit.sv
// tb_memory_interface_unit: randomized bench with behavioural model for memory_interface_unit
module tb_memory_interface_unit;
  localparam int TMO = 4;
`ifdef MEM_TIMEOUT_EN
  localparam bit TE = 1'b1;
`else
  localparam bit TE = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b1;
  tri0 [31:0] bus;
  logic drv;
  logic [31:0] bval;
  assign bus = drv ? bval : {32{1'bz}};
  logic MAR_read, MDR_read, MDR_write, mem_rd_start, mem_wr_start, mem_ack;
  logic [31:0] mem_rdata, mem_wdata;
  logic mem_busy, mem_done, mem_error, mem_we, mem_req;
  logic [15:0] mem_addr;
  int vectors = 0, miscompares = 0;

  memory_interface_unit #(.ADDR_WIDTH(16), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .bus(bus), .MAR_read(MAR_read), .MDR_read(MDR_read),
    .MDR_write(MDR_write), .mem_rd_start(mem_rd_start), .mem_wr_start(mem_wr_start),
    .mem_busy(mem_busy), .mem_done(mem_done), .mem_error(mem_error), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_req(mem_req), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  logic [15:0] m_mar, m_addr;
  logic [31:0] m_mdr, m_wdata;
  bit m_inflight, m_done, m_err, m_we;
  int m_waited;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic mreset();
    m_mar = 0; m_addr = 0; m_mdr = 0; m_wdata = 0;
    m_inflight = 0; m_done = 0; m_err = 0; m_we = 0; m_waited = 0;
  endtask

  task automatic compare();
    chk("busy", mem_busy, m_inflight || m_done);
    chk("done", mem_done, m_done);
    chk("error", mem_error, m_done && m_err);
    chk("req", mem_req, m_inflight);
    chk("addr", mem_addr, m_addr);
    chk("we", mem_we, m_we);
    chk("wdata", mem_wdata, ((m_inflight || m_done) && m_we) ? m_wdata : m_mdr);
  endtask

  // called at a negedge; applies one cycle of inputs and advances the model across the posedge
  task automatic step(input bit mr, dr, dw, rs, ws, d, input logic [31:0] bv,
                      input bit ack, input logic [31:0] rd);
    logic [31:0] bus_v;
    logic [15:0] n_mar, n_addr;
    logic [31:0] n_mdr, n_wdata;
    bit n_inflight, n_done, n_err, n_we;
    int n_waited;
    compare();
    MAR_read = mr; MDR_read = dr; MDR_write = dw; mem_rd_start = rs; mem_wr_start = ws;
    drv = d && !dw; bval = bv; mem_ack = ack; mem_rdata = rd;
    #1;
    if (dw) chk("bus_mdr", bus, m_mdr);
    bus_v = dw ? m_mdr : (drv ? bv : 32'h0);
    n_mar = mr ? bus_v[15:0] : m_mar;
    n_addr = m_addr; n_mdr = m_mdr; n_wdata = m_wdata; n_we = m_we;
    n_inflight = m_inflight; n_done = 1'b0; n_err = m_err; n_waited = m_waited;
    if (!m_inflight && !m_done) begin
      if (dr) n_mdr = bus_v;
      if (rs || ws) begin
        n_inflight = 1; n_addr = m_mar; n_we = !rs; n_wdata = m_mdr; n_waited = 0; n_err = 0;
      end
    end else if (m_inflight) begin
      if (ack) begin
        n_inflight = 0; n_done = 1; n_err = 0;
        if (!m_we) n_mdr = rd;
      end else begin
        n_waited = m_waited + 1;
        if (TE && n_waited == TMO) begin
          n_inflight = 0; n_done = 1; n_err = 1;
        end
      end
    end
    @(posedge clk);
    m_mar = n_mar; m_addr = n_addr; m_mdr = n_mdr; m_wdata = n_wdata; m_we = n_we;
    m_inflight = n_inflight; m_done = n_done; m_err = n_err; m_waited = n_waited;
    @(negedge clk);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic peek_mdr(input string name, input logic [31:0] exp);
    MDR_write = 1; drv = 0;
    #1 chk(name, bus, exp);
    MDR_write = 0;
  endtask

  initial begin
    int wc, dly;
    bit ack;
    MAR_read = 0; MDR_read = 0; MDR_write = 0; mem_rd_start = 0; mem_wr_start = 0;
    mem_ack = 0; mem_rdata = 0; drv = 0; bval = 0;
    mreset();
    repeat (2) @(negedge clk);
    reset = 0;
    chk("rst_req", mem_req, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_busy", mem_busy, 0);
    chk("rst_done", mem_done, 0);
    chk("rst_bus", bus, 0);
    // fetch
    step(1, 0, 0, 0, 0, 1, 32'h0001_0005, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0, 0, 0);
    chk("fetch_addr", mem_addr, 16'h0005);
    chk("fetch_we", mem_we, 0);
    chk("fetch_req", mem_req, 1);
    idle(); idle();
    step(0, 0, 0, 0, 0, 0, 0, 1, 32'hDEAD_BEEF);
    chk("fetch_done", mem_done, 1);
    idle();
    chk("fetch_done_pulse", mem_done, 0);
    peek_mdr("fetch_bus", 32'hDEAD_BEEF);
    // write
    step(1, 0, 0, 0, 0, 1, 32'd7, 0, 0);
    step(0, 1, 0, 0, 0, 1, 32'h1234_5678, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0, 0, 0);
    chk("wr_we", mem_we, 1);
    chk("wr_wdata", mem_wdata, 32'h1234_5678);
    chk("wr_addr", mem_addr, 16'd7);
    idle();
    chk("wr_addr_held", mem_addr, 16'd7);
    chk("wr_no_early_done", mem_done, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 0);
    chk("wr_done", mem_done, 1);
    idle();
    // interference during a read
    step(0, 0, 0, 1, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 1, 1, 32'hFFFF_FFFF, 0, 0);
    step(1, 0, 0, 0, 0, 1, 32'd9, 0, 0);
    chk("intf_addr", mem_addr, 16'd7);
    chk("intf_we", mem_we, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 32'hCAFE_F00D);
    idle();
    peek_mdr("intf_mdr", 32'hCAFE_F00D);
    step(0, 0, 0, 1, 0, 0, 0, 0, 0);
    chk("intf_mar9", mem_addr, 16'd9);
    step(0, 0, 0, 0, 0, 0, 0, 1, 32'h3333_4444);
    idle();
    // simultaneous starts
    step(0, 0, 0, 1, 1, 0, 0, 0, 0);
    chk("both_we", mem_we, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 32'h5555_6666);
    idle();
    // spurious ack in IDLE
    step(0, 0, 0, 0, 0, 0, 0, 1, 32'hAAAA_5555);
    chk("spur_done", mem_done, 0);
    chk("spur_busy", mem_busy, 0);
    peek_mdr("spur_mdr", 32'h5555_6666);
    // undriven bus
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0, 0, 0);
    chk("undriven_addr", mem_addr, 16'd0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 32'h7777_8888);
    idle();
    // reset mid-WAIT
    step(0, 0, 0, 1, 0, 0, 0, 0, 0);
    idle();
    #2 reset = 1;
    #1 chk("rst_async_req", mem_req, 0);
    chk("rst_async_busy", mem_busy, 0);
    mreset();
    @(posedge clk);
    @(negedge clk);
    reset = 0;
    chk("rst_no_done", mem_done, 0);
    idle();
`ifdef MEM_TIMEOUT_EN
    step(0, 0, 0, 1, 0, 0, 0, 0, 0);
    repeat (3) idle();
    chk("tmo_req_held", mem_req, 1);
    idle();
    chk("tmo_req", mem_req, 0);
    chk("tmo_done", mem_done, 1);
    chk("tmo_err", mem_error, 1);
    idle();
    chk("tmo_err_pulse", mem_error, 0);
    peek_mdr("tmo_mdr", 32'h7777_8888);
    step(0, 0, 0, 1, 0, 0, 0, 0, 0);
    repeat (3) idle();
    step(0, 0, 0, 0, 0, 0, 0, 1, 32'h9999_0000);
    chk("tmo_ack_done", mem_done, 1);
    chk("tmo_ack_err", mem_error, 0);
    idle();
`endif
    wc = 0; dly = 1;
    for (int i = 0; i < 3000; i++) begin
      if (mem_req) begin
        wc++;
        ack = (wc == dly);
      end else begin
        wc = 0;
        dly = $urandom_range(1, 6);
        ack = ($urandom_range(0, 7) == 0);
      end
      step($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 3) != 0,
           $urandom, ack, $urandom);
    end
    compare();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
